fp_accum_sequencer: RTL and testbench

Streaming accumulator front-end for FloatingPointAdder. It accepts a sequence of IEEE-754 single-precision operands on a valid/ready input port and keeps a running sum. For each operand it drives the adder's AddendA/AddendB/Go, waits for Ready and captures Result. It presents the final sum and status flags on a valid/ready output port when the last element of a sequence completes.

---
 rtl/fp_accum_sequencer_if.sv | 46 ++++
 rtl/fp_accum_sequencer.sv | 132 +++++++++++++
 tb/tb_fp_accum_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_accum_sequencer_if.sv
// Bundle of the three handshakes around the accumulator: operand stream in,
// floating-point adder request/response, and sum stream out.
interface fp_accum_sequencer_if #(
  parameter int COUNT_W = 16
);
  // Valid/ready: a beat transfers on the rising clock edge where valid and
  // ready are both high; a producer holds data stable while valid is high.
  logic [31:0]        InData;
  logic               InValid;
  logic               InLast;
  logic               InReady;

  logic [31:0]        AddendA;
  logic [31:0]        AddendB;
  logic               Go;
  logic [31:0]        Result;
  logic               AdderReady;
  logic               AdderZero;
  logic               AdderInf;
  logic               AdderNan;

  logic [31:0]        SumOut;
  logic               SumValid;
  logic               SumReady;
  logic               SumZero;
  logic               SumInf;
  logic               SumNan;
  logic               Error;
  logic [COUNT_W-1:0] ElemCount;

  modport slave (
    input  InData, InValid, InLast,
    input  Result, AdderReady, AdderZero, AdderInf, AdderNan,
    input  SumReady,
    output InReady, AddendA, AddendB, Go,
    output SumOut, SumValid, SumZero, SumInf, SumNan, Error, ElemCount
  );

  modport master (
    output InData, InValid, InLast,
    output Result, AdderReady, AdderZero, AdderInf, AdderNan,
    output SumReady,
    input  InReady, AddendA, AddendB, Go,
    input  SumOut, SumValid, SumZero, SumInf, SumNan, Error, ElemCount
  );
endinterface

// File: rtl/fp_accum_sequencer.sv
// Streaming float accumulator: feeds each operand plus the running sum to an
// external adder, captures the result, and emits the sum at end of sequence.
module fp_accum_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int COUNT_W = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  fp_accum_sequencer_if.slave bus,
  output logic [2:0]          o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GO     = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic [31:0]        r_acc;
  logic [31:0]        r_addend_a;
  logic [31:0]        r_addend_b;
  logic               r_last;
  logic [TW-1:0]      r_timer;
  logic               r_zero;
  logic               r_inf;
  logic               r_nan;
  logic [COUNT_W-1:0] r_count;
  logic               w_capture;
  logic               w_adder_done;
  logic               w_ack;

  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_adder_done = 1'b0;
    w_ack        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.InValid && r_in_ready) begin
          w_capture = 1'b1;
          w_next    = S_GO;
        end
      end
      S_GO:     w_next = S_SETTLE;
      // The adder's Ready may still be high from the previous operation here.
      S_SETTLE: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.AdderReady) begin
          w_adder_done = 1'b1;
          w_next       = r_last ? S_DONE : S_IDLE;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_next = S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (bus.SumReady) begin
          w_ack  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_acc      <= 32'h0000_0000;
      r_addend_a <= 32'h0000_0000;
      r_addend_b <= 32'h0000_0000;
      r_last     <= 1'b0;
      r_timer    <= '0;
      r_zero     <= 1'b0;
      r_inf      <= 1'b0;
      r_nan      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
      if (w_capture) begin
        r_addend_a <= r_acc;
        r_addend_b <= bus.InData;
        r_last     <= bus.InLast;
      end
      if (r_state == S_SETTLE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + TW'(1);
      end
      if (w_adder_done) begin
        r_acc  <= bus.Result;
        r_zero <= bus.AdderZero;
        r_inf  <= bus.AdderInf;
        r_nan  <= r_nan | bus.AdderNan;
        if (r_count != {COUNT_W{1'b1}}) begin
          r_count <= r_count + COUNT_W'(1);
        end
      end
      // Acceptance of the sum starts the next sequence from +0.0.
      if (w_ack) begin
        r_acc   <= 32'h0000_0000;
        r_zero  <= 1'b0;
        r_inf   <= 1'b0;
        r_nan   <= 1'b0;
        r_count <= '0;
      end
    end
  end

  assign bus.InReady   = r_in_ready;
  assign bus.AddendA   = r_addend_a;
  assign bus.AddendB   = r_addend_b;
  assign bus.Go        = (r_state == S_GO);
  assign bus.SumOut    = r_acc;
  assign bus.SumValid  = (r_state == S_DONE) || (r_state == S_ERR);
  assign bus.Error     = (r_state == S_ERR);
  assign bus.SumZero   = r_zero;
  assign bus.SumInf    = r_inf;
  assign bus.SumNan    = r_nan;
  assign bus.ElemCount = r_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fp_accum_sequencer.sv
// Bench for fp_accum_sequencer: scripted adder model plus a sum scoreboard.
module tb_fp_accum_sequencer;

  localparam int TIMEOUT = 64;
  localparam int COUNT_W = 16;
  localparam int W       = 32 + 4 + COUNT_W;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        i;
    logic        n;
    logic        hang;
  } add_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  add_t           add_q[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             go_count = 0;

  logic [31:0]        acc_m;
  logic               zero_m, inf_m, nan_m;
  logic [COUNT_W-1:0] cnt_m;

  fp_accum_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

  fp_accum_sequencer #(.TIMEOUT(TIMEOUT), .COUNT_W(COUNT_W)) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- adder model ----------------
  // Ready stays high (stale) through GO and SETTLE, drops in WAIT, then the
  // scripted result appears after a random delay unless the entry hangs.
  task automatic adder_model();
    add_t cur;
    logic go_prev;
    int   drop_cnt;
    int   res_cnt;
    go_prev = 1'b0;
    drop_cnt = 0;
    res_cnt = 0;
    cur = '0;
    bus.Result = 32'h0; bus.AdderReady = 1'b1;
    bus.AdderZero = 1'b0; bus.AdderInf = 1'b0; bus.AdderNan = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        drop_cnt = 0; res_cnt = 0; go_prev = 1'b0;
        bus.AdderReady = 1'b1;
      end else begin
        if (bus.Go === 1'b1) begin
          go_count++;
          checks++;
          if (go_prev) begin
            errors++;
            $display("FAIL go_pulse_width Go high %0d consecutive cycles, required 1", 2);
          end
          checks++;
          if (add_q.size() == 0) begin
            errors++;
            $display("FAIL go_unexpected Go pulse with no operand outstanding");
          end else begin
            cur = add_q.pop_front();
            if ({bus.AddendA, bus.AddendB} !== {cur.a, cur.b}) begin
              errors++;
              $display("FAIL addends A=%h B=%h required A=%h B=%h",
                       bus.AddendA, bus.AddendB, cur.a, cur.b);
            end
            drop_cnt = 2;
            res_cnt  = cur.hang ? -1 : int'($urandom_range(0, 3));
          end
        end else if (drop_cnt > 0) begin
          drop_cnt--;
          if (drop_cnt == 0) begin
            bus.AdderReady = 1'b0;
            if (res_cnt == 0) begin
              bus.Result = cur.res; bus.AdderZero = cur.z;
              bus.AdderInf = cur.i; bus.AdderNan = cur.n; bus.AdderReady = 1'b1;
            end
          end
        end else if (res_cnt > 0) begin
          res_cnt--;
          if (res_cnt == 0) begin
            bus.Result = cur.res; bus.AdderZero = cur.z;
            bus.AdderInf = cur.i; bus.AdderNan = cur.n; bus.AdderReady = 1'b1;
          end
        end
        go_prev = bus.Go;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    acc_m = 32'h0; zero_m = 1'b0; inf_m = 1'b0; nan_m = 1'b0; cnt_m = '0;
  endtask

  task automatic send_elem(input logic [31:0] d, input logic last, input logic [31:0] res,
                           input logic z, input logic i, input logic n, input logic hang);
    int   k;
    add_t e;
    k = 0;
    @(negedge clk);
    while (bus.InReady !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL in_ready_wait InReady=%b, required 1 within 200 cycles", bus.InReady);
    end
    e.a = acc_m; e.b = d; e.res = res; e.z = z; e.i = i; e.n = n; e.hang = hang;
    add_q.push_back(e);
    if (!hang) begin
      acc_m = res; zero_m = z; inf_m = i; nan_m = nan_m | n;
      if (cnt_m != {COUNT_W{1'b1}}) cnt_m = cnt_m + 1'b1;
    end
    if (last || hang) exp_q.push_back({acc_m, zero_m, inf_m, nan_m, hang, cnt_m});
    bus.InData = d; bus.InValid = 1'b1; bus.InLast = last;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0; bus.InLast = 1'b0;
  endtask

  task automatic wait_sum(output bit ok);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.SumValid !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 300);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sum_valid_wait SumValid=%b, required 1 within 300 cycles", bus.SumValid);
    end
  endtask

  task automatic ack_sum();
    bus.SumReady = 1'b1;
    @(posedge clk);
    #1;
    bus.SumReady = 1'b0;
    clear_model();
  endtask

  function automatic logic [W-1:0] observed();
    return {bus.SumOut, bus.SumZero, bus.SumInf, bus.SumNan, bus.Error, bus.ElemCount};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.InReady !== 1'b0 || bus.Go !== 1'b0 || bus.SumValid !== 1'b0 || bus.Error !== 1'b0 ||
        bus.SumZero !== 1'b0 || bus.SumInf !== 1'b0 || bus.SumNan !== 1'b0 ||
        bus.AddendA !== 32'h0 || bus.AddendB !== 32'h0 || bus.SumOut !== 32'h0 || bus.ElemCount !== '0) begin
      errors++;
      $display("FAIL reset_outputs InReady=%b Go=%b SumValid=%b A=%h B=%h SumOut=%h Count=%0d, required all 0",
               bus.InReady, bus.Go, bus.SumValid, bus.AddendA, bus.AddendB, bus.SumOut, bus.ElemCount);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.InReady !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_release InReady=%b state=%0d, required 1 and %0d", bus.InReady, dbg_state, ST_IDLE);
    end
    checks++;
    if (go_count != 0) begin
      errors++;
      $display("FAIL reset_go go_count=%0d, required 0", go_count);
    end
  endtask

  task automatic test_sum_basic();
    int g0;
    bit ok;
    logic [W-1:0] exp;
    g0 = go_count;
    send_elem(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_elem(32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_elem(32'h40600000, 1'b1, 32'h40D00000, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_sum(ok);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL basic_sum got %h required %h", observed(), exp);
    end
    checks++;
    if (go_count - g0 != 3) begin
      errors++;
      $display("FAIL basic_go_count got %0d required 3", go_count - g0);
    end
    ack_sum();
    checks++;
    if (bus.SumValid !== 1'b0 || bus.InReady !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack SumValid=%b InReady=%b, required 0 and 1", bus.SumValid, bus.InReady);
    end
  endtask

  task automatic test_zero_restart();
    bit ok;
    logic [W-1:0] exp;
    send_elem(32'h40A00000, 1'b0, 32'h40A00000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_elem(32'hC0A00000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_sum(ok);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL zero_sum got %h required %h", observed(), exp);
    end
    ack_sum();
    checks++;
    if (bus.SumOut !== 32'h0 || bus.ElemCount !== '0 || bus.SumZero !== 1'b0) begin
      errors++;
      $display("FAIL zero_clear SumOut=%h Count=%0d SumZero=%b, required 0 0 0",
               bus.SumOut, bus.ElemCount, bus.SumZero);
    end
  endtask

  task automatic test_inf_nan();
    bit ok;
    logic [W-1:0] exp;
    send_elem(32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_elem(32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0);
    send_elem(32'hBF800000, 1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_sum(ok);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL inf_sum got %h required %h", observed(), exp);
    end
    ack_sum();
    send_elem(32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0);
    send_elem(32'hFF800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_sum(ok);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL nan_sum got %h required %h", observed(), exp);
    end
    ack_sum();
  endtask

  task automatic test_random_seqs();
    bit ok;
    logic [W-1:0] exp;
    int len;
    for (int s = 0; s < 4; s++) begin
      len = int'($urandom_range(1, 5));
      for (int e = 0; e < len; e++) begin
        send_elem($urandom(), (e == len - 1), $urandom(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0);
      end
      wait_sum(ok);
      exp = exp_q.pop_front();
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL random_sum seq %0d got %h required %h", s, observed(), exp);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack_sum();
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    int n_wait;
    logic [W-1:0] exp;
    send_elem(32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_elem(32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b1);
    k = 0;
    n_wait = 0;
    while (bus.SumValid !== 1'b1 && k < 300) begin
      @(negedge clk);
      if (dbg_state == ST_WAIT) n_wait++;
      k++;
    end
    ok = (k < 300);
    checks++;
    if (!ok || n_wait != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycles WAIT lasted %0d cycles, required %0d", n_wait, TIMEOUT);
    end
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL timeout_sum got %h required %h", observed(), exp);
    end
    ack_sum();
    checks++;
    if (bus.InReady !== 1'b1 || dbg_state !== ST_IDLE || bus.Error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_ack InReady=%b state=%0d Error=%b, required 1 %0d 0",
               bus.InReady, dbg_state, bus.Error, ST_IDLE);
    end
  endtask

  task automatic test_done_stall();
    bit ok;
    logic [W-1:0] exp;
    logic [W-1:0] snap;
    send_elem(32'h40400000, 1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_sum(ok);
    exp = exp_q.pop_front();
    snap = observed();
    checks++;
    if (snap !== exp) begin
      errors++;
      $display("FAIL stall_sum got %h required %h", snap, exp);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== exp || bus.InReady !== 1'b0 || bus.SumValid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got %h InReady=%b SumValid=%b, required %h 0 1",
                 c, observed(), bus.InReady, bus.SumValid, exp);
      end
    end
    ack_sum();
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int k;
    logic [W-1:0] exp;
    send_elem(32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (dbg_state !== ST_WAIT && k < 20) begin
      @(negedge clk);
      k++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (k >= 20 || bus.Go !== 1'b0 || bus.SumValid !== 1'b0 || dbg_state !== ST_IDLE ||
        bus.InReady !== 1'b0 || bus.SumOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait Go=%b SumValid=%b state=%0d InReady=%b SumOut=%h, required 0 0 %0d 0 0",
               bus.Go, bus.SumValid, dbg_state, bus.InReady, bus.SumOut, ST_IDLE);
    end
    exp_q.delete();
    add_q.delete();
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_elem(32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_sum(ok);
    exp = exp_q.pop_front();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL after_reset_sum got %h required %h", observed(), exp);
    end
    ack_sum();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    bus.InData = 32'h0; bus.InValid = 1'b0; bus.InLast = 1'b0; bus.SumReady = 1'b0;
    clear_model();
    fork
      adder_model();
    join_none
    test_reset();
    test_sum_basic();
    test_zero_restart();
    test_inf_nan();
    test_random_seqs();
    test_timeout();
    test_done_stall();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
